// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch/jump redirect,
// fetch wait and HI/LO interlock. Optional counters enabled by PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int MD_MAX_CYC = 40,
  parameter int CNT_W      = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_uses_hilo,
  input  logic       id_jump,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_wreg,
  input  logic       ex_branch_taken,
  input  logic       md_start,
  input  logic       md_done,
  input  logic       imem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       md_busy,
  output logic       md_timeout
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] imem_wait_cnt
`endif
);

  // state   | meaning
  // RUN     | no mult/div in flight
  // MD_BUSY | mult/div in flight, HI/LO reads interlocked, watchdog running
  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam int WD_W = (MD_MAX_CYC > 1) ? $clog2(MD_MAX_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_MAX_CYC - 1);

  state_t          r_state, w_state_nxt;
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout;
  logic            w_wd_expire;
  logic            w_load_use, w_hilo, w_stall, w_imem_wait;

  always_comb begin
    w_state_nxt = r_state;
    w_wd_expire = 1'b0;
    case (r_state)
      RUN: begin
        if (md_start) w_state_nxt = MD_BUSY;
      end
      MD_BUSY: begin
        // done wins over a simultaneous expiry
        if (md_done) begin
          w_state_nxt = RUN;
        end else if (r_wd_cnt == WD_LAST) begin
          w_state_nxt = RUN;
          w_wd_expire = 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == MD_BUSY) r_wd_cnt <= r_wd_cnt + 1'b1;
      else                    r_wd_cnt <= '0;
      if (w_wd_expire) r_timeout <= 1'b1;
    end
  end

  assign md_busy    = (r_state == MD_BUSY);
  assign md_timeout = r_timeout;

  assign w_load_use = ex_mem_read && (ex_wreg != 5'd0) &&
                      ((ex_wreg == id_rs) || (id_uses_rt && (ex_wreg == id_rt)));
  assign w_hilo     = md_busy && id_uses_hilo;
  assign w_stall    = w_load_use || w_hilo;

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    w_imem_wait = 1'b0;
    if (!reset) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (id_jump) begin
      if_id_flush = 1'b1;
    end else if (!imem_ready) begin
      // bubble into ID while downstream keeps draining
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      w_imem_wait = 1'b1;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_imem_wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt     <= '0;
      r_flush_cnt     <= '0;
      r_imem_wait_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if ((ex_branch_taken || id_jump) && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
      if (w_imem_wait && (r_imem_wait_cnt != '1))
        r_imem_wait_cnt <= r_imem_wait_cnt + 1'b1;
    end
  end

  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;
  assign imem_wait_cnt = r_imem_wait_cnt;
`endif

endmodule
